branch_history_table: RTL

//  Local-history pattern table sitting directly upstream of predict_unit. For the aligned fetch pair at pc_now it

---
 rtl/clap_bpu_pkg.sv | 28 ++
 rtl/bht_entry_update.sv | 28 ++
 rtl/branch_history_table.sv | 149 ++++++++++++++
 3 files changed

// File: rtl/clap_bpu_pkg.sv
// Shared branch-prediction definitions: entry layout, counter constants,
// sweep FSM encoding and the saturating counter step.
package clap_bpu_pkg;

    localparam int HIST_MSB = 9;
    localparam int HIST_LSB = 8;
    localparam int CTR_W    = 2;
    localparam int ENTRY_W  = 10;

    localparam logic [CTR_W-1:0] CTR_INIT = 2'b01;
    localparam logic [CTR_W-1:0] CTR_MAX  = 2'b11;

    typedef enum logic {
        ST_CLEAR = 1'b0,
        ST_RUN   = 1'b1
    } bht_state_e;

    function automatic logic [CTR_W-1:0] ctr_step(
        input logic [CTR_W-1:0] c,
        input logic             taken
    );
        if (taken)
            return (c == CTR_MAX) ? c : c + 2'b01;
        else
            return (c == 2'b00) ? c : c - 2'b01;
    endfunction

endpackage

// File: rtl/bht_entry_update.sv
// Next-entry computation for one history-table slot: counter update on hit,
// fresh allocation on miss.
module bht_entry_update
    import clap_bpu_pkg::*;
(
    input  logic               hit_i,
    input  logic               taken_i,
    input  logic [ENTRY_W-1:0] entry_i,
    output logic [ENTRY_W-1:0] entry_o
);

    logic [1:0] hist;

    assign hist = entry_i[HIST_MSB:HIST_LSB];

    always_comb begin
        entry_o = entry_i;
        if (hit_i) begin
            entry_o[hist*CTR_W +: CTR_W] =
                ctr_step(entry_i[hist*CTR_W +: CTR_W], taken_i);
            entry_o[HIST_MSB:HIST_LSB] = {hist[0], taken_i};
        end else begin
            entry_o = {1'b0, taken_i, CTR_INIT, CTR_INIT, CTR_INIT,
                       taken_i ? 2'b10 : CTR_INIT};
        end
    end

endmodule

// File: rtl/branch_history_table.sv
// Local-history pattern table with one-stage update pipeline and sweep clear.
// Define BHT_BYPASS_EN to forward same-cycle S1 writes to the lookup outputs.
module branch_history_table
    import clap_bpu_pkg::*;
#(
    parameter int ADDR_WIDTH = 32,
    parameter int HASH_DEPTH = 5,
    parameter int TAG_WIDTH  = 8,
    parameter int PARA_WIDTH = 10
) (
    input  logic                  clk,
    input  logic                  rstn,
    input  logic                  clr,
    input  logic [ADDR_WIDTH-1:0] pc_now,
    output logic                  past_vld1,
    output logic                  past_vld2,
    output logic [PARA_WIDTH-1:0] past1,
    output logic [PARA_WIDTH-1:0] past2,
    input  logic                  upd_vld,
    output logic                  upd_rdy,
    input  logic [ADDR_WIDTH-1:0] upd_pc,
    input  logic                  upd_taken,
    output logic                  busy
);

    localparam int DEPTH  = 2**HASH_DEPTH;
    localparam int AW     = HASH_DEPTH + 1;
    localparam int TAG_LO = HASH_DEPTH + 3;
    localparam int TAG_HI = TAG_WIDTH + HASH_DEPTH + 2;

    bht_state_e            state_q;
    logic [HASH_DEPTH-1:0] sweep_q;
    logic [1:0]            valid_q [DEPTH];
    logic [TAG_WIDTH-1:0]  tag_ram [2*DEPTH];
    logic [PARA_WIDTH-1:0] ent_ram [2*DEPTH];

    logic                  s1_vld_q;
    logic                  s1_taken_q;
    logic [AW-1:0]         s1_addr_q;
    logic [TAG_WIDTH-1:0]  s1_tag_q;

    logic                  run;
    logic                  accept;
    logic                  we;
    logic                  s1_hit;
    logic [PARA_WIDTH-1:0] ent_d;

    logic [HASH_DEPTH-1:0] lk_idx;
    logic [TAG_WIDTH-1:0]  lk_tag;
    logic [AW-1:0]         lk_addr;
    logic [1:0]            hit;
    logic [PARA_WIDTH-1:0] ent [2];
    logic                  unused_bits;

    assign run     = rstn && (state_q == ST_RUN);
    assign busy    = !run;
    assign upd_rdy = run;
    assign accept  = upd_vld && run && !clr;
    assign we      = run && s1_vld_q && !clr;

    assign s1_hit = valid_q[s1_addr_q[AW-1:1]][s1_addr_q[0]]
                 && (tag_ram[s1_addr_q] == s1_tag_q);

    bht_entry_update u_upd (
        .hit_i   (s1_hit),
        .taken_i (s1_taken_q),
        .entry_i (ent_ram[s1_addr_q]),
        .entry_o (ent_d)
    );

    always_ff @(posedge clk) begin
        if (!rstn) begin
            state_q  <= ST_CLEAR;
            sweep_q  <= '0;
            s1_vld_q <= 1'b0;
        end else begin
            s1_vld_q <= accept;
            unique case (state_q)
                ST_CLEAR: begin
                    valid_q[sweep_q] <= 2'b00;
                    if (clr) begin
                        sweep_q <= '0;
                    end else if (sweep_q == HASH_DEPTH'(DEPTH-1)) begin
                        state_q <= ST_RUN;
                        sweep_q <= '0;
                    end else begin
                        sweep_q <= sweep_q + HASH_DEPTH'(1);
                    end
                end
                ST_RUN: begin
                    if (clr) begin
                        state_q <= ST_CLEAR;
                        sweep_q <= '0;
                    end else if (s1_vld_q) begin
                        valid_q[s1_addr_q[AW-1:1]][s1_addr_q[0]] <= 1'b1;
                    end
                end
                default: state_q <= ST_CLEAR;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (accept) begin
            s1_addr_q  <= {upd_pc[HASH_DEPTH+2:3], upd_pc[2]};
            s1_tag_q   <= upd_pc[TAG_HI:TAG_LO];
            s1_taken_q <= upd_taken;
        end
    end

    // Tag/counter storage carries no reset; validity lives in valid_q.
    always_ff @(posedge clk) begin
        if (we) begin
            ent_ram[s1_addr_q] <= ent_d;
            tag_ram[s1_addr_q] <= s1_tag_q;
        end
    end

    assign lk_idx = pc_now[HASH_DEPTH+2:3];
    assign lk_tag = pc_now[TAG_HI:TAG_LO];

    always_comb begin
        lk_addr = '0;
        hit     = 2'b00;
        ent[0]  = '0;
        ent[1]  = '0;
        for (int s = 0; s < 2; s++) begin
            lk_addr = {lk_idx, s[0]};
            hit[s]  = run && valid_q[lk_idx][s]
                   && (tag_ram[lk_addr] == lk_tag);
            ent[s]  = hit[s] ? ent_ram[lk_addr] : '0;
`ifdef BHT_BYPASS_EN
            if (we && (s1_addr_q == lk_addr)) begin
                hit[s] = (s1_tag_q == lk_tag);
                ent[s] = hit[s] ? ent_d : '0;
            end
`endif
        end
    end

    assign past_vld1 = hit[0];
    assign past_vld2 = hit[1];
    assign past1     = ent[0];
    assign past2     = ent[1];

    assign unused_bits = ^{pc_now[2:0], pc_now[ADDR_WIDTH-1:TAG_HI+1],
                           upd_pc[1:0], upd_pc[ADDR_WIDTH-1:TAG_HI+1]};

endmodule
